// File: rtl/seq_barrel_shifter.sv
// Multi-cycle parametrised barrel shifter: one log2 stage per clock, four shift modes,
// valid/ready handshakes on both sides.
module seq_barrel_shifter #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SHW-1:0]   shift,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [SHW-1:0] LAST = SHW'(SHW - 1);

  state_t           state;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] stage;
  logic [SHW-1:0]   cnt;
  logic [SHW-1:0]   shift_l;
  logic [1:0]       mode_l;
  int unsigned      n;

  // DONE passes out_ready straight through so a new operand can be taken on the pop edge.
  always_comb begin
    in_ready = 1'b0;
    if (!clear)
      in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  end

  // Arithmetic mode replicates the current MSB, which stays equal to the original sign.
  always_comb begin
    n     = 32'd1 << cnt;
    stage = work;
    if (shift_l[cnt]) begin
      case (mode_l)
        2'b00:   stage = (work >> n) | (work << (WIDTH - n));
        2'b01:   stage = (work << n) | (work >> (WIDTH - n));
        2'b10:   stage = work >> n;
        default: stage = $unsigned($signed(work) >>> n);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state     <= IDLE;
      work      <= '0;
      cnt       <= '0;
      shift_l   <= '0;
      mode_l    <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work    <= data_in;
            shift_l <= shift;
            mode_l  <= mode;
            cnt     <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          work <= stage;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            data_out  <= stage;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              work    <= data_in;
              shift_l <= shift;
              mode_l  <= mode;
              cnt     <= '0;
              state   <= SHIFT;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_barrel_shifter.sv
// Self-checking bench for seq_barrel_shifter at WIDTH 8, 16 and 32 against a bit-level reference model.
module tb_seq_barrel_shifter;

  logic        clk;
  logic [2:0]  clr;
  logic        iv;
  logic        ordy;
  logic [31:0] din;
  logic [4:0]  sh;
  logic [1:0]  md;

  logic        ir8, ir16, ir32, ov8, ov16, ov32;
  logic [7:0]  dout8;
  logic [15:0] dout16;
  logic [31:0] dout32;

  int          cur;
  logic        cur_ir, cur_ov;
  logic [31:0] cur_dout;

  int tests = 0;
  int fails = 0;
  int issued = 0;
  int seen = 0;
  logic rand_rdy = 1'b0;

  seq_barrel_shifter #(.WIDTH(8)) u8 (
    .clk(clk), .clear(clr[0]), .in_valid(iv), .in_ready(ir8), .data_in(din[7:0]),
    .shift(sh[2:0]), .mode(md), .out_valid(ov8), .out_ready(ordy), .data_out(dout8));
  seq_barrel_shifter #(.WIDTH(16)) u16 (
    .clk(clk), .clear(clr[1]), .in_valid(iv), .in_ready(ir16), .data_in(din[15:0]),
    .shift(sh[3:0]), .mode(md), .out_valid(ov16), .out_ready(ordy), .data_out(dout16));
  seq_barrel_shifter #(.WIDTH(32)) u32 (
    .clk(clk), .clear(clr[2]), .in_valid(iv), .in_ready(ir32), .data_in(din),
    .shift(sh), .mode(md), .out_valid(ov32), .out_ready(ordy), .data_out(dout32));

  always_comb begin
    case (cur)
      0:       begin cur_ir = ir8;  cur_ov = ov8;  cur_dout = {24'b0, dout8};  end
      1:       begin cur_ir = ir16; cur_ov = ov16; cur_dout = {16'b0, dout16}; end
      default: begin cur_ir = ir32; cur_ov = ov32; cur_dout = dout32;          end
    endcase
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: result bit i is taken directly from the operand by the full shift amount.
  function automatic logic [31:0] ref_op(input int w, input logic [31:0] d, input int s,
                                         input logic [1:0] m);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < w; i++) begin
      case (m)
        2'b00:   r[i] = d[(i + s) % w];
        2'b01:   r[i] = d[(i - s + w) % w];
        2'b10:   r[i] = (i + s < w) ? d[i + s] : 1'b0;
        default: r[i] = (i + s < w) ? d[i + s] : d[w - 1];
      endcase
    end
    return r;
  endfunction

  // Cycle model of the protocol, evaluated on the falling edge with the inputs the next rising edge samples.
  int          m_st = 0;   // 0 idle, 1 busy, 2 result held
  int          m_left = 0;
  logic [31:0] m_res = '0;
  logic [31:0] m_dout = '0;
  logic        m_ov = 1'b0;

  always @(negedge clk) begin
    logic rdy_now;
    rdy_now = !clr[cur] && (m_st == 0 || (m_st == 2 && ordy));
    chk("out_valid", {31'b0, cur_ov}, {31'b0, m_ov});
    chk("data_out", cur_dout, m_dout);
    chk("in_ready", {31'b0, cur_ir}, {31'b0, rdy_now});
    if (cur_ov && ordy) seen++;
    if (clr[cur]) begin
      m_st = 0; m_dout = '0; m_ov = 1'b0;
    end else begin
      case (m_st)
        0: if (iv) begin
          m_res = ref_op(8 << cur, din, int'(sh), md); m_left = 3 + cur; m_st = 1;
        end
        1: begin
          m_left--;
          if (m_left == 0) begin m_dout = m_res; m_ov = 1'b1; m_st = 2; end
        end
        default: if (ordy) begin
          m_ov = 1'b0;
          if (iv) begin
            m_res = ref_op(8 << cur, din, int'(sh), md); m_left = 3 + cur; m_st = 1;
          end else m_st = 0;
        end
      endcase
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) ordy = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic issue(input logic [31:0] d, input int s, input logic [1:0] m);
    logic got;
    din = d; sh = 5'(s); md = m; iv = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (cur_ir) begin got = 1'b1; break; end
    end
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    iv = 1'b0;
    issued++;
  endtask

  task automatic wait_result(output int lat);
    logic got;
    got = 1'b0;
    lat = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (cur_ov) begin got = 1'b1; break; end
    end
    if (!got) chk("result_timeout", 32'd0, 32'd1);
  endtask

  task automatic directed(input logic [31:0] d, input int s, input logic [1:0] m,
                          input logic [31:0] exp);
    int lat;
    issue(d, s, m);
    wait_result(lat);
    chk("dir_result", cur_dout, exp);
    chk("dir_latency", 32'(lat), 32'd3);
    @(posedge clk);
    #1;
  endtask

  task automatic switch_to(input int n);
    clr[cur] = 1'b1;
    @(posedge clk);
    #1;
    cur = n;
    @(posedge clk);
    #1;
    clr[n] = 1'b0;
    issued = 0;
    seen = 0;
  endtask

  task automatic random_phase(input int nops);
    int w;
    w = 8 << cur;
    rand_rdy = 1'b1;
    for (int i = 0; i < nops; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      issue($urandom, $urandom_range(0, w - 1), 2'($urandom_range(0, 3)));
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #2;
    ordy = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("results_vs_issued", 32'(seen), 32'(issued));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    cur = 0; clr = 3'b111; iv = 1'b0; ordy = 1'b1; din = '0; sh = '0; md = '0;

    // Pin the reference model with hand-computed values.
    r = ref_op(8, 32'hB4, 3, 2'b00); chk("model_ror", r, 32'h96);
    r = ref_op(8, 32'hB4, 3, 2'b01); chk("model_rol", r, 32'hA5);
    r = ref_op(8, 32'hB4, 3, 2'b10); chk("model_lsr", r, 32'h16);
    r = ref_op(8, 32'hB4, 3, 2'b11); chk("model_asr", r, 32'hF6);
    r = ref_op(16, 32'h8001, 1, 2'b00); chk("model_ror16", r, 32'hC000);

    // Reset: two clear edges, in_ready low throughout, idle afterwards.
    repeat (2) begin
      @(negedge clk);
      chk("ready_in_clear", {31'b0, cur_ir}, 32'd0);
    end
    @(posedge clk);
    #1;
    clr[0] = 1'b0;
    @(negedge clk);
    chk("reset_dout", cur_dout, 32'h0);
    chk("reset_ov", {31'b0, cur_ov}, 32'd0);
    chk("idle_ready", {31'b0, cur_ir}, 32'd1);
    @(posedge clk);
    #1;

    directed(32'hB4, 3, 2'b00, 32'h96);
    directed(32'hB4, 3, 2'b01, 32'hA5);
    directed(32'hB4, 3, 2'b10, 32'h16);
    directed(32'hB4, 3, 2'b11, 32'hF6);
    for (int m = 0; m < 4; m++) directed(32'hB4, 0, 2'(m), 32'hB4);
    directed(32'h81, 7, 2'b00, 32'h03);
    directed(32'h80, 7, 2'b11, 32'hFF);
    directed(32'h80, 7, 2'b10, 32'h01);

    // Backpressure with a pending operand, then accept on the pop edge.
    begin
      int lat;
      ordy = 1'b0;
      issue(32'hB4, 3, 2'b00);
      wait_result(lat);
      chk("bp_result", cur_dout, 32'h96);
      @(posedge clk);
      #1;
      din = 32'h0F; sh = 5'd4; md = 2'b01; iv = 1'b1;
      repeat (5) begin
        @(negedge clk);
        chk("bp_ov_hold", {31'b0, cur_ov}, 32'd1);
        chk("bp_dout_hold", cur_dout, 32'h96);
        chk("bp_ready_low", {31'b0, cur_ir}, 32'd0);
      end
      @(posedge clk);
      #1;
      ordy = 1'b1;
      @(negedge clk);
      chk("bp_ready_pass", {31'b0, cur_ir}, 32'd1);
      @(posedge clk);
      #1;
      iv = 1'b0;
      wait_result(lat);
      chk("bp_next_result", cur_dout, 32'hF0);
      chk("bp_next_latency", 32'(lat), 32'd3);
      @(posedge clk);
      #1;
    end

    // Clear on the second busy edge aborts the operation.
    issue(32'hB4, 3, 2'b00);
    @(posedge clk);
    #1;
    clr[0] = 1'b1;
    @(posedge clk);
    #1;
    clr[0] = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("abort_ov", {31'b0, cur_ov}, 32'd0);
      chk("abort_dout", cur_dout, 32'h0);
    end
    chk("abort_idle", {31'b0, cur_ir}, 32'd1);
    @(posedge clk);
    #1;

    switch_to(1);
    random_phase(1000);
    switch_to(2);
    random_phase(1000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_barrel_shifter.md
Name: seq_barrel_shifter

Overview:
- Parametrised, multi-cycle barrel shifter; successor to the fixed 8-bit, rotate-right-only, stage-per-clock shifter.
- Processes one log2 stage per clock: stage k shifts by 2^k when shift[k] is set.
- Generalised in width, and adds four shift modes plus valid/ready handshakes on input and output.
- Sits in the datapath between a producer and a consumer that may stall.

Parameters:
- WIDTH, 8, data width in bits; must be a power of two, at least 2.
- SHW, $clog2(WIDTH) (derived, not overridden), shift-amount width and number of stages.

Ports:
- clk  in  1  clock, rising edge.
- clear  in  1  reset; synchronous, active-high.
- in_valid  in  1  input operand valid.
- in_ready  out  1  block can accept an operand this cycle.
- data_in  in  WIDTH  operand.
- shift  in  SHW  shift amount, 0..WIDTH-1.
- mode  in  2  operation select: 00 rotate right, 01 rotate left, 10 logical shift right, 11 arithmetic shift right.
- out_valid  out  1  data_out holds a completed result.
- out_ready  in  1  consumer takes the result this cycle.
- data_out  out  WIDTH  result.

Behaviour:
- Reset: clear sampled high at a rising edge gives state IDLE, data_out = 0, out_valid = 0, and clears the working register, the stage counter, and the latched shift/mode.
  - in_ready is forced to 0 in any cycle where clear = 1.
  - Reset mid-operation aborts the operation; no result is produced.
- Accept: in IDLE, in_ready = 1. An edge with in_valid & in_ready does the following:
  - work <= data_in; latches shift and mode; cnt <= 0; state goes to SHIFT.
  - data_in, shift and mode are don't-care after acceptance.
- SHIFT state:
  - in_ready = 0.
  - Each edge applies stage cnt to work: if shift_l[cnt] = 1, operate by 2^cnt according to mode_l, else pass work through.
  - Then cnt increments.
  - On the edge where cnt = SHW-1: data_out <= stage result, out_valid <= 1, state goes to DONE.
  - Exactly SHW stage edges are applied, including for shift = 0; there is no early exit.
- Latency: out_valid goes high after the SHW-th edge following the accept edge (3 for WIDTH = 8). Fixed and data-independent.
- Mode arithmetic per stage, by n = 2^k:
  - Rotate right: {w[n-1:0], w[W-1:n]}.
  - Rotate left: {w[W-n-1:0], w[W-1:W-n]}.
  - Logical shift right: zero-fill from the MSB side.
  - Arithmetic shift right: fill with the original bit W-1. Sign is preserved because every stage replicates the current MSB, which equals the original sign.
  - Composition of stages equals a single operation by the full shift amount.
- DONE state:
  - out_valid = 1; data_out is held stable until the handshake.
  - in_ready = out_ready. Combinational path, documented; no other combinational in-to-out path exists.
  - Edge with out_ready = 1 and in_valid = 0: out_valid <= 0, state goes to IDLE.
  - Edge with out_ready = 1 and in_valid = 1: out_valid <= 0, the new operand is accepted as in IDLE, state goes to SHIFT. This gives back-to-back throughput of one result per SHW+1 cycles.
  - Edge with out_ready = 0: hold everything; in_valid is ignored.
- data_out changes only at the completion edge or at reset. Between results it keeps the last value, with out_valid = 0.
- in_valid while busy (SHIFT) is ignored. The producer must hold in_valid until it sees in_ready.

Test Plan:
- Reset, then idle: clear = 1 for 2 cycles, then 0 → data_out = 0x00, out_valid = 0, in_ready = 1 the cycle after clear drops; in_ready = 0 during clear.
- WIDTH = 8, data_in = 0xB4, shift = 3, each mode with out_ready = 1 → out_valid high exactly 3 edges after accept, with results:
  - mode 00 → 0x96
  - mode 01 → 0xA5
  - mode 10 → 0x16
  - mode 11 → 0xF6
- Boundaries:
  - 0xB4, shift = 0 → 0xB4 in all modes, still 3-cycle latency.
  - 0x81, shift = 7, mode 00 → 0x03.
  - 0x80, shift = 7, mode 11 → 0xFF.
  - 0x80, shift = 7, mode 10 → 0x01.
- Backpressure: out_ready = 0 for 5 cycles after result 0x96 → out_valid and data_out stable, in_ready = 0, a pending in_valid is not accepted. Raise out_ready with in_valid = 1, data_in = 0x0F, shift = 4, mode 01 → accepted on the same edge, next result 0xF0 after 3 further edges.
- Reset mid-operation: accept 0xB4/shift 3, assert clear on the second SHIFT edge → out_valid never rises, data_out = 0x00, block returns to IDLE.
- Parameter sweep: WIDTH = 16 and 32, random data/shift/mode, 1000 operations with random out_ready stalls → every result matches the reference model; latency = SHW (4 and 5); no lost or duplicated results.
